// File: rtl/battle_pkg.sv
// Shared types and defaults for the battleship turn sequencer.
// Holds the state encoding exported on the display port, plus the ship-count defaults.
package battle_pkg;

  localparam int unsigned SHIP_W          = 3;
  localparam int unsigned DEF_MAX_SHIPS   = 5;
  localparam int unsigned DEF_MIN_SHIPS   = 1;
  localparam int unsigned DEF_TIMEOUT_CYC = 750_000_000;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SELECT      = 3'd1,
    PLACE       = 3'd2,
    PLAYER_TURN = 3'd3,
    PC_TURN     = 3'd4,
    WIN         = 3'd5,
    LOSE        = 3'd6
  } state_t;

endpackage

// File: rtl/turn_timer.sv
// Player-turn timeout counter: zero while clear, counts while run, expired is combinational.
// The expiry pulse lasts exactly one cycle because the owner leaves the counting state on it. No backpressure.
module turn_timer #(
  parameter int unsigned TIMEOUT_CYC = 750_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = run && (count_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run && !expired) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battleship game sequencer: select -> place -> alternating turns; all outputs registered (1-cycle latency).
// No backpressure: pulses outside their state are dropped. BATTLE_TURN_TIMER_EN adds the player-turn timeout.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned MAX_SHIPS   = DEF_MAX_SHIPS,
  parameter int unsigned MIN_SHIPS   = DEF_MIN_SHIPS,
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              btn_inc,
  input  logic              btn_ok,
  input  logic              place_done,
  input  logic              player_shot,
  input  logic              pc_shot_done,
  input  logic              pc_lost,
  input  logic              player_lost,
  output logic [SHIP_W-1:0] ship_count,
  output logic [SHIP_W-1:0] place_idx,
  output logic              place_en,
  output logic              pc_fire,
  output logic              auto_fire,
  output logic [2:0]        state,
  output logic              game_over,
  output logic              win
);

  localparam logic [SHIP_W-1:0] MAX_CNT = SHIP_W'(MAX_SHIPS);
  localparam logic [SHIP_W-1:0] MIN_CNT = SHIP_W'(MIN_SHIPS);

  state_t            state_q, state_d;
  logic [SHIP_W-1:0] ship_count_q, ship_count_d;
  logic [SHIP_W-1:0] place_idx_q, place_idx_d;
  logic              place_en_q, place_en_d;
  logic              pc_fire_q, pc_fire_d;
  logic              auto_fire_q, auto_fire_d;
  logic              game_over_q, game_over_d;
  logic              win_q, win_d;
  logic              tmr_expired;

`ifdef BATTLE_TURN_TIMER_EN
  turn_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_q != PLAYER_TURN),
    .run     (state_q == PLAYER_TURN),
    .expired (tmr_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC == 0);
  assign tmr_expired    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ship_count_d = ship_count_q;
    place_idx_d  = place_idx_q;
    auto_fire_d  = 1'b0;

    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d      = SELECT;
          ship_count_d = MIN_CNT;
          place_idx_d  = '0;
        end
      end
      SELECT: begin
        if (btn_ok) begin
          state_d     = PLACE;
          place_idx_d = '0;
        end else if (btn_inc) begin
          ship_count_d = (ship_count_q >= MAX_CNT) ? MIN_CNT : ship_count_q + SHIP_W'(1);
        end
      end
      PLACE: begin
        if (place_done) begin
          if (place_idx_q >= ship_count_q - SHIP_W'(1)) begin
            state_d     = PLAYER_TURN;
            place_idx_d = '0;
          end else begin
            place_idx_d = place_idx_q + SHIP_W'(1);
          end
        end
      end
      // Loss detection takes priority over any shot event in the same cycle.
      PLAYER_TURN: begin
        if (pc_lost) begin
          state_d = WIN;
        end else if (player_lost) begin
          state_d = LOSE;
        end else if (player_shot) begin
          state_d = PC_TURN;
        end else if (tmr_expired) begin
          state_d     = PC_TURN;
          auto_fire_d = 1'b1;
        end
      end
      PC_TURN: begin
        if (pc_lost) begin
          state_d = WIN;
        end else if (player_lost) begin
          state_d = LOSE;
        end else if (pc_shot_done) begin
          state_d = PLAYER_TURN;
        end
      end
      default: state_d = IDLE;
    endcase

    pc_fire_d   = (state_d == PC_TURN) && (state_q != PC_TURN);
    place_en_d  = (state_d == PLACE);
    game_over_d = (state_d == WIN) || (state_d == LOSE);
    win_d       = (state_d == WIN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      ship_count_q <= MIN_CNT;
      place_idx_q  <= '0;
      place_en_q   <= 1'b0;
      pc_fire_q    <= 1'b0;
      auto_fire_q  <= 1'b0;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ship_count_q <= ship_count_d;
      place_idx_q  <= place_idx_d;
      place_en_q   <= place_en_d;
      pc_fire_q    <= pc_fire_d;
      auto_fire_q  <= auto_fire_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
    end
  end

  assign state      = state_q;
  assign ship_count = ship_count_q;
  assign place_idx  = place_idx_q;
  assign place_en   = place_en_q;
  assign pc_fire    = pc_fire_q;
  assign auto_fire  = auto_fire_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Directed bench for battle_turn_ctrl with TIMEOUT_CYC=20; timer scenario follows BATTLE_TURN_TIMER_EN.
module tb_battle_turn_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_SELECT = 3'd1, S_PLACE = 3'd2, S_PLAYER = 3'd3;
  localparam logic [2:0] S_PC = 3'd4, S_WIN = 3'd5, S_LOSE = 3'd6;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 0, btn_inc = 0, btn_ok = 0, place_done = 0;
  logic       player_shot = 0, pc_shot_done = 0, pc_lost = 0, player_lost = 0;
  logic [2:0] ship_count, place_idx, state;
  logic       place_en, pc_fire, auto_fire, game_over, win;

  int pass_cnt  = 0;
  int total_cnt = 0;

  battle_turn_ctrl #(
    .MAX_SHIPS   (5),
    .MIN_SHIPS   (1),
    .TIMEOUT_CYC (20)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .btn_inc      (btn_inc),
    .btn_ok       (btn_ok),
    .place_done   (place_done),
    .player_shot  (player_shot),
    .pc_shot_done (pc_shot_done),
    .pc_lost      (pc_lost),
    .player_lost  (player_lost),
    .ship_count   (ship_count),
    .place_idx    (place_idx),
    .place_en     (place_en),
    .pc_fire      (pc_fire),
    .auto_fire    (auto_fire),
    .state        (state),
    .game_over    (game_over),
    .win          (win)
  );

  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 time unit later and pulse inputs dropped.
  task automatic tick();
    @(posedge clk);
    #1;
    start = 0; btn_inc = 0; btn_ok = 0; place_done = 0;
    player_shot = 0; pc_shot_done = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (2) tick();
    total_cnt++; if (state !== S_IDLE) $display("FAIL rst_state got %0d want %0d", state, S_IDLE); else pass_cnt++;
    total_cnt++; if (ship_count !== 3'd1) $display("FAIL rst_count got %0d want 1", ship_count); else pass_cnt++;
    total_cnt++; if ({place_en, pc_fire, auto_fire, game_over, win, place_idx} !== 8'd0)
      $display("FAIL rst_outs got %b want 0", {place_en, pc_fire, auto_fire, game_over, win, place_idx}); else pass_cnt++;
    rst = 1;
    tick();
    btn_inc = 1; tick();
    total_cnt++; if (ship_count !== 3'd1) $display("FAIL idle_ignore_inc got %0d want 1", ship_count); else pass_cnt++;
  endtask

  task automatic test_select();
    logic [2:0] exp_cnt [5];
    exp_cnt = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    start = 1; tick();
    total_cnt++; if (state !== S_SELECT) $display("FAIL start_state got %0d want %0d", state, S_SELECT); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      btn_inc = 1; tick();
      total_cnt++; if (ship_count !== exp_cnt[i]) $display("FAIL inc_%0d got %0d want %0d", i, ship_count, exp_cnt[i]); else pass_cnt++;
    end
    btn_inc = 1; tick();
    btn_inc = 1; tick();
    btn_inc = 1; btn_ok = 1; tick();
    total_cnt++; if (state !== S_PLACE) $display("FAIL incok_state got %0d want %0d", state, S_PLACE); else pass_cnt++;
    total_cnt++; if (ship_count !== 3'd3) $display("FAIL incok_count got %0d want 3", ship_count); else pass_cnt++;
    total_cnt++; if (place_en !== 1'b1 || place_idx !== 3'd0) $display("FAIL place_entry got en=%b idx=%0d want en=1 idx=0", place_en, place_idx); else pass_cnt++;
  endtask

  task automatic test_place();
    player_shot = 1; tick();
    total_cnt++; if (state !== S_PLACE) $display("FAIL place_ignore_shot got %0d want %0d", state, S_PLACE); else pass_cnt++;
    place_done = 1; tick();
    total_cnt++; if (place_idx !== 3'd1) $display("FAIL place_idx1 got %0d want 1", place_idx); else pass_cnt++;
    tick();
    total_cnt++; if (place_idx !== 3'd1 || place_en !== 1'b1) $display("FAIL place_hold got idx=%0d en=%b want idx=1 en=1", place_idx, place_en); else pass_cnt++;
    place_done = 1; tick();
    total_cnt++; if (place_idx !== 3'd2) $display("FAIL place_idx2 got %0d want 2", place_idx); else pass_cnt++;
    place_done = 1; tick();
    total_cnt++; if (state !== S_PLAYER) $display("FAIL place_last_state got %0d want %0d", state, S_PLAYER); else pass_cnt++;
    total_cnt++; if (place_en !== 1'b0 || place_idx !== 3'd0) $display("FAIL place_last_outs got en=%b idx=%0d want en=0 idx=0", place_en, place_idx); else pass_cnt++;
  endtask

  task automatic test_turns();
    pc_shot_done = 1; tick();
    total_cnt++; if (state !== S_PLAYER) $display("FAIL player_ignore_pcdone got %0d want %0d", state, S_PLAYER); else pass_cnt++;
    player_shot = 1; tick();
    total_cnt++; if (state !== S_PC || pc_fire !== 1'b1) $display("FAIL shot_to_pc got st=%0d fire=%b want st=%0d fire=1", state, pc_fire, S_PC); else pass_cnt++;
    btn_inc = 1; player_shot = 1; tick();
    total_cnt++; if (state !== S_PC || pc_fire !== 1'b0) $display("FAIL pc_fire_once got st=%0d fire=%b want st=%0d fire=0", state, pc_fire, S_PC); else pass_cnt++;
    total_cnt++; if (ship_count !== 3'd3) $display("FAIL pc_ignore_inc got %0d want 3", ship_count); else pass_cnt++;
    pc_shot_done = 1; tick();
    total_cnt++; if (state !== S_PLAYER || pc_fire !== 1'b0) $display("FAIL pcdone_to_player got st=%0d fire=%b want st=%0d fire=0", state, pc_fire, S_PLAYER); else pass_cnt++;
  endtask

  task automatic test_timer();
    logic seen_auto;
`ifdef BATTLE_TURN_TIMER_EN
    seen_auto = 0;
    repeat (19) begin tick(); seen_auto |= auto_fire; end
    total_cnt++; if (state !== S_PLAYER || seen_auto) $display("FAIL tmr_early got st=%0d auto=%b want st=%0d auto=0", state, seen_auto, S_PLAYER); else pass_cnt++;
    tick();
    total_cnt++; if (state !== S_PC || auto_fire !== 1'b1 || pc_fire !== 1'b1)
      $display("FAIL tmr_expire got st=%0d auto=%b fire=%b want st=%0d auto=1 fire=1", state, auto_fire, pc_fire, S_PC); else pass_cnt++;
    tick();
    total_cnt++; if (auto_fire !== 1'b0) $display("FAIL tmr_auto_once got %b want 0", auto_fire); else pass_cnt++;
    pc_shot_done = 1; tick();
    repeat (19) tick();
    player_shot = 1; tick();
    total_cnt++; if (state !== S_PC || auto_fire !== 1'b0 || pc_fire !== 1'b1)
      $display("FAIL tmr_shot_race got st=%0d auto=%b fire=%b want st=%0d auto=0 fire=1", state, auto_fire, pc_fire, S_PC); else pass_cnt++;
    tick();
    total_cnt++; if (state !== S_PC || auto_fire !== 1'b0) $display("FAIL tmr_race_after got st=%0d auto=%b want st=%0d auto=0", state, auto_fire, S_PC); else pass_cnt++;
`else
    seen_auto = 0;
    repeat (30) begin tick(); seen_auto |= auto_fire; end
    total_cnt++; if (state !== S_PLAYER || seen_auto) $display("FAIL notmr_wait got st=%0d auto=%b want st=%0d auto=0", state, seen_auto, S_PLAYER); else pass_cnt++;
    player_shot = 1; tick();
`endif
    pc_shot_done = 1; tick();
    total_cnt++; if (state !== S_PLAYER) $display("FAIL tmr_return got %0d want %0d", state, S_PLAYER); else pass_cnt++;
  endtask

  task automatic test_win_lose();
    pc_lost = 1; player_shot = 1; tick();
    total_cnt++; if (state !== S_WIN || win !== 1'b1 || game_over !== 1'b1 || pc_fire !== 1'b0)
      $display("FAIL win_entry got st=%0d win=%b go=%b fire=%b want st=%0d win=1 go=1 fire=0", state, win, game_over, pc_fire, S_WIN); else pass_cnt++;
    pc_lost = 0; btn_ok = 1; tick();
    total_cnt++; if (state !== S_WIN) $display("FAIL win_hold got %0d want %0d", state, S_WIN); else pass_cnt++;
    start = 1; tick();
    total_cnt++; if (state !== S_SELECT || ship_count !== 3'd1 || game_over !== 1'b0 || win !== 1'b0)
      $display("FAIL win_restart got st=%0d cnt=%0d go=%b win=%b want st=%0d cnt=1 go=0 win=0", state, ship_count, game_over, win, S_SELECT); else pass_cnt++;
    btn_ok = 1; tick();
    place_done = 1; tick();
    player_shot = 1; tick();
    player_lost = 1; pc_shot_done = 1; tick();
    total_cnt++; if (state !== S_LOSE || win !== 1'b0 || game_over !== 1'b1)
      $display("FAIL lose_entry got st=%0d win=%b go=%b want st=%0d win=0 go=1", state, win, game_over, S_LOSE); else pass_cnt++;
    player_lost = 0; start = 1; tick();
    btn_ok = 1; tick();
    place_done = 1; tick();
    pc_lost = 1; player_lost = 1; tick();
    total_cnt++; if (state !== S_WIN || win !== 1'b1) $display("FAIL both_lost got st=%0d win=%b want st=%0d win=1", state, win, S_WIN); else pass_cnt++;
    pc_lost = 0; player_lost = 0;
  endtask

  task automatic test_reset_mid_place();
    start = 1; tick();
    btn_inc = 1; tick();
    btn_ok = 1; tick();
    place_done = 1; tick();
    total_cnt++; if (state !== S_PLACE || place_idx !== 3'd1) $display("FAIL mid_setup got st=%0d idx=%0d want st=%0d idx=1", state, place_idx, S_PLACE); else pass_cnt++;
    #2 rst = 0;
    #1;
    total_cnt++; if (state !== S_IDLE || ship_count !== 3'd1 || place_en !== 1'b0 || place_idx !== 3'd0)
      $display("FAIL mid_rst got st=%0d cnt=%0d en=%b idx=%0d want st=0 cnt=1 en=0 idx=0", state, ship_count, place_en, place_idx); else pass_cnt++;
    tick();
    rst = 1;
    tick();
    total_cnt++; if (state !== S_IDLE || ship_count !== 3'd1) $display("FAIL post_rst got st=%0d cnt=%0d want st=0 cnt=1", state, ship_count); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_select();
    test_place();
    test_turns();
    test_timer();
    test_win_lose();
    test_reset_mid_place();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
